// File: rtl/logic_gate_pkg.sv
// Shared types and constants for the pipelined logic-gate block and its self-test engine.
package logic_gate_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NAND  = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOT_A = 3'd6,
        OP_BUF_A = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sweep_state_e;

    localparam int SWEEP_LEN = 32;

    // Bit {op, a, b} is the single-lane result of op applied to a and b.
    localparam logic [31:0] GOLDEN = 32'hC396_17E8;

endpackage

// File: rtl/logic_gate_core.sv
// Purely combinational WIDTH-lane bitwise operation decoder.
module logic_gate_core
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_NAND:  y = ~(a & b);
            OP_NOR:   y = ~(a | b);
            OP_XOR:   y = a ^ b;
            OP_XNOR:  y = ~(a ^ b);
            OP_NOT_A: y = ~a;
            OP_BUF_A: y = a;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Streaming bitwise gate with a 2-entry output buffer, handshake counter and
// an exhaustive truth-table self-test sweep sharing the single core.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    input  logic             flt_inj,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic             sweep_pass,
    output logic [CNT_W-1:0] txn_cnt
);

    sweep_state_e     state, state_nxt;
    logic [4:0]       k;
    logic             fail;
    logic             pass_r;

    logic [WIDTH-1:0] fifo_mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;

    op_e              core_op;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic [WIDTH-1:0] core_y;
    logic [WIDTH-1:0] res;
    logic             vec_err;
    logic             push;
    logic             pop;

    // The core is shared: sweep vectors take over its inputs while running.
    always_comb begin
        if (state == ST_RUN) begin
            core_op = op_e'(k[4:2]);
            core_a  = {WIDTH{k[1]}};
            core_b  = {WIDTH{k[0]}};
        end else begin
            core_op = op_e'(op);
            core_a  = a;
            core_b  = b;
        end
    end

    logic_gate_core #(.WIDTH(WIDTH)) u_core (
        .op (core_op),
        .a  (core_a),
        .b  (core_b),
        .y  (core_y)
    );

    assign res     = core_y ^ WIDTH'(flt_inj);
    assign vec_err = (res != {WIDTH{GOLDEN[k]}});

    assign in_ready   = (count != 2'd2) && (state == ST_IDLE);
    assign out_valid  = (count != 2'd0);
    assign y          = out_valid ? fifo_mem[rd_ptr] : '0;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;

    assign sweep_busy = (state == ST_RUN);
    assign sweep_done = (state == ST_DONE);
    assign sweep_pass = (state == ST_DONE) ? !fail : pass_r;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (sweep_start) state_nxt = ST_RUN;
            ST_RUN:  if (k == 5'(SWEEP_LEN - 1)) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            k      <= '0;
            fail   <= 1'b0;
            pass_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_RUN) k <= k + 5'd1;
            else                 k <= '0;
            if (state == ST_IDLE && sweep_start)
                fail <= 1'b0;
            else if (state == ST_RUN && vec_err)
                fail <= 1'b1;
            if (state == ST_DONE)
                pass_r <= !fail;
        end
    end

    // Buffer control and handshake counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            txn_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                txn_cnt <= txn_cnt + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Buffer storage needs no reset; out_valid masks stale entries.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= res;
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Randomized self-checking bench for logic_gate_pipe against a queue-based reference model.
module tb_logic_gate_pipe;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       op = '0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] y;
    logic             flt_inj = 1'b0;
    logic             sweep_start = 1'b0;
    logic             sweep_busy;
    logic             sweep_done;
    logic             sweep_pass;
    logic [CNT_W-1:0] txn_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] mq[$];
    logic [CNT_W-1:0] mcnt = '0;

    always #5 clk = ~clk;

    logic_gate_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .flt_inj(flt_inj), .sweep_start(sweep_start),
        .sweep_busy(sweep_busy), .sweep_done(sweep_done),
        .sweep_pass(sweep_pass), .txn_cnt(txn_cnt)
    );

    function automatic logic [WIDTH-1:0] ref_y(input logic [2:0] o,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] z,
                                               input logic f);
        logic [WIDTH-1:0] r;
        case (o)
            3'd0:    r = x & z;
            3'd1:    r = x | z;
            3'd2:    r = ~(x & z);
            3'd3:    r = ~(x | z);
            3'd4:    r = x ^ z;
            3'd5:    r = ~(x ^ z);
            3'd6:    r = ~x;
            default: r = x;
        endcase
        r[0] = r[0] ^ f;
        return r;
    endfunction

    task automatic report(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_fail++;
        if (n_fail <= 40)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // One idle-state cycle: compare DUT outputs to the model, then advance both.
    task automatic step();
        logic exp_rdy;
        logic do_pop;
        logic do_push;
        exp_rdy = (mq.size() < 2);
        n_tests++; if (in_ready !== exp_rdy) report("in_ready", 32'(in_ready), 32'(exp_rdy));
        n_tests++; if (out_valid !== (mq.size() != 0)) report("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            n_tests++; if (y !== mq[0]) report("y", 32'(y), 32'(mq[0]));
        end
        n_tests++; if (txn_cnt !== mcnt) report("txn_cnt", 32'(txn_cnt), 32'(mcnt));
        do_pop  = (mq.size() != 0) && out_ready;
        do_push = in_valid && exp_rdy;
        if (do_pop) begin
            void'(mq.pop_front());
            mcnt = mcnt + 1'b1;
        end
        if (do_push) mq.push_back(ref_y(op, a, b, flt_inj));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_sweep(input logic flt, input logic exp_pass);
        in_valid    = 1'b0;
        flt_inj     = flt;
        n_tests++; if (sweep_busy !== 1'b0) report("sweep_busy_pre", 32'(sweep_busy), 32'h0);
        sweep_start = 1'b1;
        for (int i = 0; i < 34; i++) begin
            if (i >= 1 && i <= 32) begin
                n_tests++; if (sweep_busy !== 1'b1) report("sweep_busy", 32'(sweep_busy), 32'h1);
                n_tests++; if (sweep_done !== 1'b0) report("sweep_done_run", 32'(sweep_done), 32'h0);
                n_tests++; if (in_ready !== 1'b0) report("in_ready_run", 32'(in_ready), 32'h0);
            end
            if (i == 33) begin
                n_tests++; if (sweep_done !== 1'b1) report("sweep_done", 32'(sweep_done), 32'h1);
                n_tests++; if (sweep_busy !== 1'b0) report("sweep_busy_done", 32'(sweep_busy), 32'h0);
                n_tests++; if (sweep_pass !== exp_pass) report("sweep_pass", 32'(sweep_pass), 32'(exp_pass));
                n_tests++; if (in_ready !== 1'b0) report("in_ready_done", 32'(in_ready), 32'h0);
            end
            n_tests++; if (out_valid !== (mq.size() != 0)) report("out_valid_sweep", 32'(out_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                n_tests++; if (y !== mq[0]) report("y_sweep", 32'(y), 32'(mq[0]));
                if (out_ready) begin
                    void'(mq.pop_front());
                    mcnt = mcnt + 1'b1;
                end
            end
            @(posedge clk);
            @(negedge clk);
            sweep_start = 1'b0;
        end
        n_tests++; if (sweep_done !== 1'b0) report("sweep_done_after", 32'(sweep_done), 32'h0);
        n_tests++; if (sweep_pass !== exp_pass) report("sweep_pass_hold", 32'(sweep_pass), 32'(exp_pass));
        n_tests++; if (in_ready !== (mq.size() < 2)) report("in_ready_after", 32'(in_ready), 32'(mq.size() < 2));
        n_tests++; if (txn_cnt !== mcnt) report("txn_cnt_sweep", 32'(txn_cnt), 32'(mcnt));
        flt_inj = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_tests++; if (out_valid !== 1'b0) report({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        n_tests++; if (y !== '0) report({tag, "_y"}, 32'(y), 32'h0);
        n_tests++; if (txn_cnt !== '0) report({tag, "_txn_cnt"}, 32'(txn_cnt), 32'h0);
        n_tests++; if (sweep_busy !== 1'b0) report({tag, "_sweep_busy"}, 32'(sweep_busy), 32'h0);
        n_tests++; if (sweep_done !== 1'b0) report({tag, "_sweep_done"}, 32'(sweep_done), 32'h0);
        n_tests++; if (sweep_pass !== 1'b0) report({tag, "_sweep_pass"}, 32'(sweep_pass), 32'h0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_pulse");
        mq.delete();
        mcnt = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        check_reset_outputs("reset");
        n_tests++; if (in_ready !== 1'b1) report("reset_in_ready", 32'(in_ready), 32'h1);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ops();
        logic [WIDTH-1:0] tbl [8];
        tbl = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 8'hF0;
        b = 8'hCC;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                n_tests++; if (y !== tbl[i-1]) report("op_table_y", 32'(y), 32'(tbl[i-1]));
                n_tests++; if (out_valid !== 1'b1) report("op_table_valid", 32'(out_valid), 32'h1);
            end
            if (i == 8) in_valid = 1'b0;
            else        op = 3'(i);
            step();
        end
        n_tests++; if (txn_cnt !== 16'd8) report("op_table_txn_cnt", 32'(txn_cnt), 32'd8);
    endtask

    task automatic test_backpressure();
        logic [CNT_W-1:0] start_cnt;
        start_cnt = mcnt;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = WIDTH'($urandom);
            b  = WIDTH'($urandom);
            step();
        end
        n_tests++; if (in_ready !== 1'b0) report("bp_in_ready", 32'(in_ready), 32'h0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_tests++; if (txn_cnt !== start_cnt + 16'd2) report("bp_txn_cnt", 32'(txn_cnt), 32'(start_cnt + 16'd2));
    endtask

    task automatic test_push_pop();
        logic [CNT_W-1:0] start_cnt;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = 3'd4; a = 8'h5A; b = 8'h0F;
        step();
        start_cnt = txn_cnt;
        out_ready = 1'b1;
        op = 3'd1; a = 8'h12; b = 8'h40;
        step();
        n_tests++; if (out_valid !== 1'b1) report("pp_out_valid", 32'(out_valid), 32'h1);
        n_tests++; if (y !== 8'h52) report("pp_y", 32'(y), 32'h52);
        n_tests++; if (txn_cnt !== start_cnt + 16'd1) report("pp_txn_cnt", 32'(txn_cnt), 32'(start_cnt + 16'd1));
        in_valid = 1'b0;
        step();
        n_tests++; if (out_valid !== 1'b0) report("pp_drained", 32'(out_valid), 32'h0);
    endtask

    task automatic test_sweep_pass();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = 3'd0; a = 8'hAA; b = 8'hFF;
        step();
        op = 3'd7; a = 8'h33;
        step();
        out_ready = 1'b1;
        run_sweep(1'b0, 1'b1);
    endtask

    task automatic test_sweep_fault();
        run_sweep(1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_sweep();
        run_sweep(1'b0, 1'b1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = 3'd2; a = 8'h81; b = 8'h18;
        step();
        in_valid = 1'b0;
        sweep_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sweep_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_tests++; if (sweep_busy !== 1'b1) report("mid_busy_before", 32'(sweep_busy), 32'h1);
        n_tests++; if (out_valid !== 1'b1) report("mid_valid_before", 32'(out_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_sweep");
        mq.delete();
        mcnt = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        run_sweep(1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            flt_inj   = ($urandom_range(0, 7) == 0);
            op = 3'($urandom_range(0, 7));
            a  = WIDTH'($urandom);
            b  = WIDTH'($urandom);
            step();
        end
        in_valid  = 1'b0;
        flt_inj   = 1'b0;
        out_ready = 1'b1;
        step();
        step();
    endtask

    task automatic test_wrap();
        pulse_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        op = 3'd5;
        for (int i = 0; i < 70000 && mcnt != 16'hFFFF; i++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            step();
        end
        n_tests++; if (txn_cnt !== 16'hFFFF) report("wrap_preload", 32'(txn_cnt), 32'hFFFF);
        in_valid = 1'b0;
        step();
        n_tests++; if (txn_cnt !== 16'h0000) report("wrap_zero", 32'(txn_cnt), 32'h0);
    endtask

    initial begin
        test_reset();
        test_ops();
        test_backpressure();
        test_push_pop();
        test_sweep_pass();
        test_sweep_fault();
        test_reset_mid_sweep();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_gate_pipe.md
# logic_gate_pipe

Parametrised, pipelined successor to the single-bit two-input gate primitives. It applies one of eight selectable bitwise logic operations across WIDTH lanes. Results pass through a valid/ready handshake with a 2-entry output buffer. A built-in sweep engine checks the datapath exhaustively against a golden truth table and reports pass/fail. The block sits between any streaming producer and consumer in the logic-primitive library.

## Interface
Parameters:
- WIDTH, 8, number of bit lanes in a, b, y (≥1)
- CNT_W, 16, width of the completed-transaction counter

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- op  in  3  operation: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 BUF a
- a, b  in  WIDTH  operands (b ignored for op 6/7)
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- y  out  WIDTH  result
- flt_inj  in  1  fault injection: inverts lane 0 of the core output while high
- sweep_start  in  1  one-cycle request to run self-test
- sweep_busy  out  1  sweep engine running
- sweep_done  out  1  one-cycle pulse at sweep end
- sweep_pass  out  1  result of last completed sweep
- txn_cnt  out  CNT_W  count of output handshakes, wraps

## Operation
- Output buffer: 2-entry FIFO holding WIDTH-bit results.
- in_ready = (FIFO count < 2) && state == IDLE.
- Accept when in_valid && in_ready. The core result (with flt_inj applied) is pushed into the FIFO.
- out_valid = count != 0; y = head entry. Pop on out_valid && out_ready.
- Push and pop in the same cycle leave count unchanged. At count 2, in_ready = 0, so there is no push.
- txn_cnt increments on every pop and wraps 2^CNT_W−1 → 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when sweep_start = 1. sweep_start in RUN or DONE is ignored.
  - RUN lasts exactly 32 cycles, with vector index k = 0..31 and one vector per cycle: op = k[4:2], a = {WIDTH{k[1]}}, b = {WIDTH{k[0]}}.
  - Each cycle, every lane of the core output is compared to golden bit GOLDEN[k]. Any mismatch sets a sticky fail flag.
  - RUN→DONE after k = 31. DONE→IDLE after 1 cycle.
  - In DONE: sweep_done = 1 and sweep_pass ← !fail. sweep_pass holds until the next DONE.
- sweep_busy = (state == RUN). Sweep vectors are never pushed to the FIFO. The FIFO keeps draining during RUN and DONE.
- If sweep_start and an accepted in_valid coincide in IDLE, the beat is accepted and the sweep begins on the next cycle.
- Reset (asynchronous, any time including mid-sweep) forces:
  - state IDLE, FIFO empty
  - out_valid 0, y 0, txn_cnt 0
  - sweep_busy 0, sweep_done 0, sweep_pass 0, fail flag cleared

## Timing
- Latency: a beat accepted at edge t is visible on y/out_valid after edge t (1 cycle).
- Throughput: 1 beat/cycle while out_ready = 1.
- in_ready is combinational from the registered count and state only; there is no combinational path from out_ready or in_valid.
- A sweep request sampled at edge t gives sweep_busy high from t+1 to t+32, and sweep_done high for the cycle after t+32.
- The earliest in_ready after a sweep is the cycle after sweep_done.

## Structure
- Package logic_gate_pkg holds:
  - op encoding as a 3-bit enum
  - GOLDEN: 32-bit constant truth table, bit index {op, a, b}
  - SWEEP_LEN = 32
- Sub-module logic_gate_core: purely combinational WIDTH-lane op decoder.
  - One instance; its inputs are muxed between the external operands and the sweep vector.
  - flt_inj is applied after the core.

## Test plan
- Reset, then for each op drive a = 8'hF0, b = 8'hCC with out_ready = 1 → y = C0, FC, 3F, 03, 3C, C3, 0F, F0, each one cycle after acceptance; txn_cnt = 8.
- Hold out_ready = 0 and offer 3 beats → first 2 accepted, then in_ready = 0. Release out_ready → results drain in order with no loss or duplication.
- With count = 1, push and pop in the same cycle → count stays 1 and txn_cnt increments.
- Pulse sweep_start with flt_inj = 0 → sweep_busy is high for 32 cycles, then sweep_done pulses with sweep_pass = 1. in_ready is 0 throughout.
- Repeat the sweep with flt_inj = 1 → sweep_pass = 0.
- Assert rst at k = 10 of a sweep → all outputs return to reset values immediately. A new sweep then passes normally.
- Preload txn_cnt to 2^16−1 via 65535 handshakes, then do one more pop → txn_cnt = 0.
